// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Size is carried by funct3[1:0]; any encoding other than b/h behaves as a word.
    function automatic logic [3:0] wstrb_for(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] strb;
        case (funct3[1:0])
            F3_B[1:0]: strb = 4'b0001 << off;
            F3_H[1:0]: strb = off[1] ? 4'b1100 : 4'b0011;
            default:   strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational lane select and sign/zero extension of a raw load word.
module load_extend #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [2:0]            funct3,
    input  logic [1:0]            off,
    output logic [DATA_WIDTH-1:0] result
);
    import lsu_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        // funct3[2] selects zero extension for the unsigned variants.
        case (funct3[1:0])
            F3_B[1:0]: result = funct3[2] ? {{(DATA_WIDTH-8){1'b0}}, byte_sel}
                                          : {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_H[1:0]: result = funct3[2] ? {{(DATA_WIDTH-16){1'b0}}, half_sel}
                                          : {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            default:   result = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage_lsu.sv
// Memory-stage LSU: drives a req/gnt/rvalid data bus and stalls the pipeline until done.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned accesses skip the bus and flag misalignedm).
module memory_stage_lsu #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     memreadm,
    input  logic                     memwritem,
    input  logic [2:0]               funct3m,
    input  logic [ADDRESS_WIDTH-1:0] aluresultm,
    input  logic [DATA_WIDTH-1:0]    writedatam,
    output logic [DATA_WIDTH-1:0]    readdatam,
    output logic                     stallm,
    output logic                     misalignedm,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [3:0]               mem_wstrb,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);
    import lsu_pkg::*;

    lsu_state_e            state, state_next;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] ext_data;
    logic                  mis_q;
    logic                  acc;
    logic                  mis;
    logic                  capture;
    logic [1:0]            off;

    assign acc = memreadm | memwritem;
    assign off = aluresultm[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = acc & ((funct3m[1] & (off != 2'b00)) |
                        ((funct3m[1:0] == F3_H[1:0]) & off[0]));
`else
    assign mis = 1'b0;
`endif

    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
        .rdata  (mem_rdata),
        .funct3 (funct3m),
        .off    (off),
        .result (ext_data)
    );

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        stallm     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (acc) begin
                    stallm = 1'b1;
                    if (mis) begin
                        state_next = DONE;
                    end else begin
                        mem_req = 1'b1;
                        if (mem_gnt) state_next = memwritem ? DONE : RESP;
                        else         state_next = REQ;
                    end
                end
            end
            REQ: begin
                mem_req = 1'b1;
                stallm  = 1'b1;
                if (mem_gnt) state_next = memwritem ? DONE : RESP;
            end
            RESP: begin
                stallm = 1'b1;
                if (mem_rvalid) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            data_q <= '0;
            mis_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE) mis_q <= mis;
            // A trapped access reports zero instead of stale load data.
            if (capture)                    data_q <= ext_data;
            else if (state == IDLE && mis)  data_q <= '0;
        end
    end

    assign readdatam   = data_q;
    assign misalignedm = (state == DONE) & mis_q;
    assign mem_we      = mem_req & memwritem;
    assign mem_addr    = {aluresultm[ADDRESS_WIDTH-1:2], 2'b00};
    assign mem_wstrb   = (mem_req & memwritem) ? wstrb_for(funct3m, off) : 4'b0000;

    always_comb begin
        case (funct3m[1:0])
            F3_B[1:0]: mem_wdata = {4{writedatam[7:0]}};
            F3_H[1:0]: mem_wdata = {2{writedatam[15:0]}};
            default:   mem_wdata = writedatam;
        endcase
    end

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Directed testbench for memory_stage_lsu.
module tb_memory_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        memreadm, memwritem;
    logic [2:0]  funct3m;
    logic [31:0] aluresultm, writedatam;
    logic [31:0] readdatam;
    logic        stallm, misalignedm;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_stage_lsu #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .memreadm(memreadm), .memwritem(memwritem), .funct3m(funct3m),
        .aluresultm(aluresultm), .writedatam(writedatam),
        .readdatam(readdatam), .stallm(stallm), .misalignedm(misalignedm),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic idle_inputs();
        memreadm   = 1'b0;
        memwritem  = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    // Load with immediate gnt and rvalid; returns observations only.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                           output logic [31:0] rd, output int stalls, output logic [31:0] addr_o,
                           output logic mis_o);
        @(negedge clk);
        memreadm = 1'b1; memwritem = 1'b0; funct3m = f3; aluresultm = addr;
        mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = rdata;
        stalls = 0;
        #1 addr_o = mem_addr;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) #1;
            if (!stallm) break;
            stalls++;
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b1;
        end
        rd = readdatam;
        mis_o = misalignedm;
        idle_inputs();
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [3:0] strb_o, output logic [31:0] wdata_o,
                            output logic we_o, output logic [31:0] addr_o, output int stalls);
        @(negedge clk);
        memreadm = 1'b0; memwritem = 1'b1; funct3m = f3; aluresultm = addr;
        writedatam = wdata; mem_gnt = 1'b1; mem_rvalid = 1'b0;
        #1;
        strb_o = mem_wstrb; wdata_o = mem_wdata; we_o = mem_we; addr_o = mem_addr;
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) #1;
            if (!stallm) break;
            stalls++;
            @(negedge clk);
            mem_gnt = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        funct3m = 3'b010; aluresultm = '0; writedatam = '0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (readdatam !== 32'h0) begin errors++; $display("FAIL reset_readdatam got %h exp %h", readdatam, 32'h0); end
        checks++; if (stallm !== 1'b0) begin errors++; $display("FAIL reset_stallm got %b exp 0", stallm); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
        checks++; if (misalignedm !== 1'b0) begin errors++; $display("FAIL reset_misalignedm got %b exp 0", misalignedm); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_word();
        logic [3:0] strb; logic [31:0] wd, ad; logic we; int st;
        do_store(3'b010, 32'h100, 32'hDEADBEEF, strb, wd, we, ad, st);
        checks++; if (strb !== 4'b1111) begin errors++; $display("FAIL sw_wstrb got %b exp 1111", strb); end
        checks++; if (wd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h exp deadbeef", wd); end
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL sw_we got %b exp 1", we); end
        checks++; if (ad !== 32'h100) begin errors++; $display("FAIL sw_addr got %h exp 00000100", ad); end
        checks++; if (st != 1) begin errors++; $display("FAIL sw_stall_cycles got %0d exp 1", st); end
    endtask

    task automatic test_load_byte();
        logic [31:0] rd, ad; int st; logic mis;
        do_load(3'b000, 32'h103, 32'h80FF_0000, rd, st, ad, mis);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_readdata got %h exp ffffff80", rd); end
        checks++; if (st != 2) begin errors++; $display("FAIL lb_stall_cycles got %0d exp 2", st); end
        do_load(3'b100, 32'h103, 32'h80FF_0000, rd, st, ad, mis);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_readdata got %h exp 00000080", rd); end
    endtask

    task automatic test_load_half_stall();
        int req_cnt, stall_cnt;
        logic [31:0] rd, ad; int st; logic mis;
        @(negedge clk);
        memreadm = 1'b1; funct3m = 3'b001; aluresultm = 32'h102; mem_rdata = 32'h8001_1234;
        req_cnt = 0; stall_cnt = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc > 0) @(negedge clk);
            mem_gnt    = (cyc == 3);
            mem_rvalid = (cyc == 5);
            #1;
            if (mem_req) req_cnt++;
            if (!stallm) break;
            stall_cnt++;
        end
        checks++; if (req_cnt != 4) begin errors++; $display("FAIL lh_req_cycles got %0d exp 4", req_cnt); end
        checks++; if (stall_cnt != 6) begin errors++; $display("FAIL lh_stall_cycles got %0d exp 6", stall_cnt); end
        checks++; if (readdatam !== 32'hFFFF8001) begin errors++; $display("FAIL lh_readdata got %h exp ffff8001", readdatam); end
        idle_inputs();
        do_load(3'b101, 32'h100, 32'h8001_1234, rd, st, ad, mis);
        checks++; if (rd !== 32'h00001234) begin errors++; $display("FAIL lhu_readdata got %h exp 00001234", rd); end
    endtask

    task automatic test_store_byte();
        logic [3:0] strb; logic [31:0] wd, ad; logic we; int st;
        do_store(3'b000, 32'h201, 32'h0000_00AB, strb, wd, we, ad, st);
        checks++; if (wd !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata got %h exp abababab", wd); end
        checks++; if (strb !== 4'b0010) begin errors++; $display("FAIL sb_wstrb got %b exp 0010", strb); end
        checks++; if (ad !== 32'h200) begin errors++; $display("FAIL sb_addr got %h exp 00000200", ad); end
        checks++; if (readdatam !== 32'h00001234) begin errors++; $display("FAIL sb_keeps_readdata got %h exp 00001234", readdatam); end
        do_store(3'b001, 32'h302, 32'h0000_5678, strb, wd, we, ad, st);
        checks++; if (strb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb got %b exp 1100", strb); end
        checks++; if (wd !== 32'h56785678) begin errors++; $display("FAIL sh_wdata got %h exp 56785678", wd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, ad; int st; logic mis;
        @(negedge clk);
        memreadm = 1'b1; funct3m = 3'b010; aluresultm = 32'h300; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        checks++; if (stallm !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_in_resp got stall=%b req=%b exp stall=1 req=0", stallm, mem_req); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        #1;
        checks++; if (stallm !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_idle got stall=%b req=%b exp 0 0", stallm, mem_req); end
        checks++; if (readdatam !== 32'h0) begin errors++; $display("FAIL rstmid_readdata got %h exp 00000000", readdatam); end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        checks++; if (readdatam !== 32'h0) begin errors++; $display("FAIL rstmid_stray_rvalid got %h exp 00000000", readdatam); end
        do_load(3'b010, 32'h104, 32'hCAFEF00D, rd, st, ad, mis);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rstmid_next_load got %h exp cafef00d", rd); end
        checks++; if (st != 2) begin errors++; $display("FAIL rstmid_next_stall got %0d exp 2", st); end
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        memreadm = 1'b1; funct3m = 3'b010; aluresultm = 32'h102; mem_gnt = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mis_no_req got %b exp 0", mem_req); end
        checks++; if (stallm !== 1'b1) begin errors++; $display("FAIL mis_stall got %b exp 1", stallm); end
        @(negedge clk);
        #1;
        checks++; if (misalignedm !== 1'b1) begin errors++; $display("FAIL mis_flag got %b exp 1", misalignedm); end
        checks++; if (readdatam !== 32'h0) begin errors++; $display("FAIL mis_readdata got %h exp 00000000", readdatam); end
        checks++; if (stallm !== 1'b0) begin errors++; $display("FAIL mis_done_stall got %b exp 0", stallm); end
        idle_inputs();
        @(negedge clk);
        #1;
        checks++; if (misalignedm !== 1'b0) begin errors++; $display("FAIL mis_one_cycle got %b exp 0", misalignedm); end
`else
        logic [31:0] rd, ad; int st; logic mis;
        do_load(3'b010, 32'h102, 32'h11223344, rd, st, ad, mis);
        checks++; if (ad !== 32'h100) begin errors++; $display("FAIL lw_unaligned_addr got %h exp 00000100", ad); end
        checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL lw_unaligned_data got %h exp 11223344", rd); end
        checks++; if (mis !== 1'b0) begin errors++; $display("FAIL lw_unaligned_flag got %b exp 0", mis); end
`endif
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_load_half_stall();
        test_store_byte();
        test_reset_mid();
        test_misalign();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "timeout");
    end

endmodule
